// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the Wishbone master arbiter:
//   arb_state_e : FSM state encoding (ST_IDLE / ST_BUS)
//   TO_RDATA    : read data returned to a master whose transaction timed out
//   CNT_W       : width of the ack-timeout counter
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } arb_state_e;

    localparam logic [31:0] TO_RDATA = 32'h0000_0000;
    localparam int          CNT_W    = 16;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Search starts at (last+1) mod N and
// wraps; the first set bit of req found on the way wins.
// Ports:
//   req  [N-1:0]  request vector
//   last [IW-1:0] index of the previous owner
//   pick [N-1:0]  one-hot winner, all-zero when req is all-zero
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  pick
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    int idx;

    // Walk from the farthest candidate to the nearest so the nearest
    // requester (last+1) overwrites any earlier hit.
    always_comb begin
        pick = '0;
        idx  = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx[IW-1:0]]) begin
                pick = ONE << idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_master_arb.sv
// -----------------------------------------------------------------------------
// wb_master_arb
// Round-robin arbiter letting N_MST Wishbone masters share one slave bus.
// A two-state FSM (ST_IDLE / ST_BUS) registers a grant, muxes the owner onto
// the slave bus and passes s_ack back combinationally to the owner only.
// Every transaction ends in ST_IDLE, so consecutive grants are separated by
// exactly one idle cycle.
//
// Optional feature (macro WB_MASTER_ARB_TIMEOUT_EN): an ack timeout. After
// TO_CYCLES ST_BUS cycles with no s_ack the owner receives an ack with
// m_rdata = 0 and err_to pulses. Without the macro err_to is tied low.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   m_addr/m_wdata/m_we  per-master request fields (master i at [W*i +: W])
//   m_cyc                per-master cycle request, held until acked
//   m_rdata, m_ack       read data broadcast, per-master ack pulse
//   s_addr/s_wdata/s_we/s_cyc, s_rdata/s_ack   shared slave bus
//   grant                one-hot current owner, zero when idle
//   err_to               one-cycle timeout pulse
// -----------------------------------------------------------------------------
module wb_master_arb
    import wb_arb_pkg::*;
#(
    parameter int N_MST     = 2,
    parameter int TO_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [24*N_MST-1:0] m_addr,
    input  logic [32*N_MST-1:0] m_wdata,
    input  logic [N_MST-1:0]    m_we,
    input  logic [N_MST-1:0]    m_cyc,
    output logic [31:0]         m_rdata,
    output logic [N_MST-1:0]    m_ack,
    output logic [23:0]         s_addr,
    output logic [31:0]         s_wdata,
    output logic                s_we,
    output logic                s_cyc,
    input  logic [31:0]         s_rdata,
    input  logic                s_ack,
    output logic [N_MST-1:0]    grant,
    output logic                err_to
);

    localparam int IW = $clog2(N_MST);

    if (N_MST < 2 || N_MST > 4 || TO_CYCLES < 1 || TO_CYCLES > 65535) begin : g_param_chk
        $error("wb_master_arb: N_MST or TO_CYCLES out of range");
    end

    arb_state_e       state_q, state_d;
    logic [N_MST-1:0] grant_q, grant_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    last_q,  last_d;
    logic [N_MST-1:0] pick;
    logic [IW-1:0]    pick_idx;

    rr_pick #(.N(N_MST), .IW(IW)) u_rr_pick (
        .req  (m_cyc),
        .last (last_q),
        .pick (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

`ifdef WB_MASTER_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_to_c;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        m_ack   = '0;
        m_rdata = s_rdata;
        s_cyc   = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_we    = 1'b0;
`ifdef WB_MASTER_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_to_c = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc) begin
                    state_d = ST_BUS;
                    grant_d = pick;
                    owner_d = pick_idx;
`ifdef WB_MASTER_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUS: begin
                s_cyc   = m_cyc[owner_q];
                s_addr  = m_addr[24*owner_q +: 24];
                s_wdata = m_wdata[32*owner_q +: 32];
                s_we    = m_we[owner_q];
                if (s_ack) begin
                    // A real ack always beats a coincident timeout.
                    m_ack[owner_q] = 1'b1;
                    state_d        = ST_IDLE;
                    grant_d        = '0;
                    last_d         = owner_q;
                end else if (!m_cyc[owner_q]) begin
                    // Owner abandoned the cycle: release without an ack.
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
`ifdef WB_MASTER_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TO_CYCLES)) begin
                    m_ack[owner_q] = 1'b1;
                    err_to_c       = 1'b1;
                    m_rdata        = TO_RDATA;
                    s_cyc          = 1'b0;
                    state_d        = ST_IDLE;
                    grant_d        = '0;
                    last_d         = owner_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IW'(N_MST - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

`ifdef WB_MASTER_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign err_to = err_to_c;
`else
    assign err_to = 1'b0;
`endif

    assign grant = grant_q;

endmodule
